// File: rtl/alu_driver.sv
// Request/response shim around a registered ALU: forwards operands,
// tracks one in-flight op and buffers results in a small FIFO.
module alu_driver #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [31:0]                req_op1_i,
   input  logic [31:0]                req_op2_i,
   input  logic [1:0]                 req_operator_i,
   input  logic [3:0]                 req_tag_i,
   output logic [31:0]                alu_operand1_o,
   output logic [31:0]                alu_operand2_o,
   output logic [1:0]                 alu_operator_o,
   input  logic [31:0]                alu_result_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [31:0]                rsp_result_o,
   output logic [3:0]                 rsp_tag_o,
   output logic [$clog2(DEPTH):0]     occupancy_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic              inflight_q, inflight_d;
   logic [3:0]        tag_q, tag_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     occ_q, occ_d;
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic              accept;
   logic              wr_en;
   logic              pop;

   logic [31:0]       res_mem [DEPTH];
   logic [3:0]        tag_mem [DEPTH];

   assign alu_operand1_o = req_op1_i;
   assign alu_operand2_o = req_op2_i;
   assign alu_operator_o = req_operator_i;

   // Reserve a slot for the in-flight op so its result always has room.
   assign req_ready_o = !rst && ((count_q + CW'(inflight_q)) < DEPTH_C);
   assign rsp_valid_o = (count_q != '0);

   assign accept = req_valid_i && req_ready_o;
   assign wr_en  = inflight_q && !rst;
   assign pop    = rsp_valid_o && rsp_ready_i && !rst;

   assign rsp_result_o = res_mem[rptr_q];
   assign rsp_tag_o    = tag_mem[rptr_q];
   assign occupancy_o  = occ_q;

   always_comb begin
      inflight_d = accept;
      tag_d      = tag_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      if (accept) begin
         tag_d = req_tag_i;
      end
      if (wr_en) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      unique case (1'b1)
         (wr_en && !pop): count_d = count_q + CW'(1);
         (!wr_en && pop): count_d = count_q - CW'(1);
         default:         count_d = count_q;
      endcase
      occ_d = count_d + CW'(inflight_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         tag_q      <= 4'd0;
         count_q    <= '0;
         occ_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         count_q    <= count_d;
         occ_q      <= occ_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         res_mem[wptr_q] <= alu_result_i;
         tag_mem[wptr_q] <= tag_q;
      end
   end

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: registered ALU model plus a queue-based
// reference of accepted-but-unconsumed operations.
module tb_alu_driver;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [31:0]   req_op1_i = '0;
   logic [31:0]   req_op2_i = '0;
   logic [1:0]    req_operator_i = '0;
   logic [3:0]    req_tag_i = '0;
   logic [31:0]   alu_operand1_o;
   logic [31:0]   alu_operand2_o;
   logic [1:0]    alu_operator_o;
   logic [31:0]   alu_result_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b0;
   logic [31:0]   rsp_result_o;
   logic [3:0]    rsp_tag_o;
   logic [CW-1:0] occupancy_o;

   int checks   = 0;
   int failures = 0;

   logic [35:0] exp_q [$];
   bit          acc_last = 1'b0;
   bit          m_acc    = 1'b0;
   bit          m_pop    = 1'b0;
   int          acc_n;

   alu_driver #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_op1_i      (req_op1_i),
      .req_op2_i      (req_op2_i),
      .req_operator_i (req_operator_i),
      .req_tag_i      (req_tag_i),
      .alu_operand1_o (alu_operand1_o),
      .alu_operand2_o (alu_operand2_o),
      .alu_operator_o (alu_operator_o),
      .alu_result_i   (alu_result_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_result_o   (rsp_result_o),
      .rsp_tag_o      (rsp_tag_o),
      .occupancy_o    (occupancy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [1:0]  op);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   // External ALU: result registered one cycle after operands.
   always @(posedge clk)
      alu_result_i <= alu_f(alu_operand1_o, alu_operand2_o, alu_operator_o);

   task automatic chk(input string tag, input logic [35:0] obs,
                      input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_in(input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] op,
                           input logic [3:0] tg, input bit r,
                           input bit rs);
      bit m_rdy;
      int bc;
      @(negedge clk);
      rst            = rs;
      req_valid_i    = v;
      req_op1_i      = a;
      req_op2_i      = b;
      req_operator_i = op;
      req_tag_i      = tg;
      rsp_ready_i    = r;
      #1;
      m_rdy = !rs && (exp_q.size() < DEPTH);
      bc    = exp_q.size() - int'(acc_last);
      chk("ready", 36'(req_ready_o), 36'(m_rdy));
      chk("alu_op1", 36'(alu_operand1_o), 36'(a));
      chk("alu_op2", 36'(alu_operand2_o), 36'(b));
      chk("alu_opr", 36'(alu_operator_o), 36'(op));
      if (!rs) begin
         chk("rsp_valid", 36'(rsp_valid_o), 36'(bc > 0));
         chk("occupancy", 36'(occupancy_o), 36'(exp_q.size()));
         if (bc > 0) begin
            chk("rsp_result", 36'(rsp_result_o), 36'(exp_q[0][31:0]));
            chk("rsp_tag", 36'(rsp_tag_o), 36'(exp_q[0][35:32]));
         end
      end
      m_acc = v && m_rdy;
      m_pop = !rs && (bc > 0) && r;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         acc_last = 1'b0;
      end else begin
         if (m_pop) void'(exp_q.pop_front());
         if (m_acc)
            exp_q.push_back({req_tag_i,
                             alu_f(req_op1_i, req_op2_i, req_operator_i)});
         acc_last = m_acc;
      end
   endtask

   task automatic step(input bit v, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] op,
                       input logic [3:0] tg, input bit r, input bit rs);
      drive_in(v, a, b, op, tg, r, rs);
      tick();
   endtask

   task automatic idle(input bit r);
      step(1'b0, $urandom, $urandom, 2'($urandom), 4'($urandom), r, 1'b0);
   endtask

   task automatic rnd_req(input logic [1:0] op, input logic [3:0] tg,
                          input bit r);
      step(1'b1, $urandom, $urandom, op, tg, r, 1'b0);
   endtask

   initial begin
      // Reset
      step(1'b0, '0, '0, 2'd0, 4'd0, 1'b0, 1'b1);
      step(1'b0, '0, '0, 2'd0, 4'd0, 1'b0, 1'b1);
      drive_in(1'b0, '0, '0, 2'd0, 4'd0, 1'b1, 1'b0);
      chk("post_rst_ready", 36'(req_ready_o), 36'd1);
      chk("post_rst_occ", 36'(occupancy_o), 36'd0);
      chk("post_rst_valid", 36'(rsp_valid_o), 36'd0);
      tick();

      // Single XOR op, tag 5
      step(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd2, 4'd5, 1'b1, 1'b0);
      idle(1'b1);
      drive_in(1'b0, '0, '0, 2'd0, 4'd0, 1'b1, 1'b0);
      chk("single_valid", 36'(rsp_valid_o), 36'd1);
      chk("single_result", 36'(rsp_result_o), 36'h0_0FF0_0FF0);
      chk("single_tag", 36'(rsp_tag_o), 36'd5);
      tick();
      idle(1'b1);

      // Streaming 8 AND ops
      for (int i = 0; i < 8; i++) begin
         drive_in(1'b1, $urandom, $urandom, 2'd0, 4'(i), 1'b1, 1'b0);
         chk("stream_ready", 36'(req_ready_o), 36'd1);
         tick();
      end
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Backpressure until full, then drain
      acc_n = 0;
      for (int i = 0; i < 7; i++) begin
         drive_in(1'b1, $urandom, $urandom, 2'($urandom_range(0, 2)),
                  4'(i), 1'b0, 1'b0);
         if (req_ready_o === 1'b1) acc_n++;
         tick();
      end
      chk("bp_accepts", 36'(acc_n), 36'd4);
      drive_in(1'b1, $urandom, $urandom, 2'd1, 4'd15, 1'b0, 1'b0);
      chk("bp_occ", 36'(occupancy_o), 36'd4);
      chk("bp_ready", 36'(req_ready_o), 36'd0);
      tick();
      for (int i = 0; i < 10; i++) rnd_req(2'd1, 4'(i), 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b1);

      // Full with in-flight write and simultaneous pop
      for (int i = 0; i < 4; i++) rnd_req(2'd2, 4'(i + 8), 1'b0);
      drive_in(1'b0, '0, '0, 2'd0, 4'd0, 1'b1, 1'b0);
      chk("full_pop_occ", 36'(occupancy_o), 36'd4);
      tick();
      drive_in(1'b0, '0, '0, 2'd0, 4'd0, 1'b0, 1'b0);
      chk("full_pop_occ2", 36'(occupancy_o), 36'd3);
      tick();
      for (int i = 0; i < 5; i++) idle(1'b1);

      // Illegal operator
      step(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 2'd3, 4'd9, 1'b1, 1'b0);
      idle(1'b1);
      drive_in(1'b0, '0, '0, 2'd0, 4'd0, 1'b1, 1'b0);
      chk("illegal_valid", 36'(rsp_valid_o), 36'd1);
      chk("illegal_result", 36'(rsp_result_o), 36'd0);
      chk("illegal_tag", 36'(rsp_tag_o), 36'd9);
      tick();

      // Reset mid-operation: 3 buffered + 1 in flight
      for (int i = 0; i < 4; i++) rnd_req(2'd1, 4'(i + 1), 1'b0);
      step(1'b0, '0, '0, 2'd0, 4'd0, 1'b0, 1'b1);
      drive_in(1'b0, '0, '0, 2'd0, 4'd0, 1'b1, 1'b0);
      chk("mid_rst_valid", 36'(rsp_valid_o), 36'd0);
      chk("mid_rst_occ", 36'(occupancy_o), 36'd0);
      chk("mid_rst_ready", 36'(req_ready_o), 36'd1);
      tick();
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Request accepted right before reset is discarded
      rnd_req(2'd0, 4'd7, 1'b1);
      step(1'b0, '0, '0, 2'd0, 4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), $urandom, $urandom,
              2'($urandom), 4'($urandom), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 60) == 0));
      end
      for (int i = 0; i < 6; i++) idle(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of response buffer entries; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid_i  input  1  request present.
REQ-005 req_ready_o  output  1  request can be accepted this cycle.
REQ-006 req_op1_i / req_op2_i  input  32 each  operands.
REQ-007 req_operator_i  input  2  operator_t encoding: AND=0, OR=1, XOR=2; 3 is illegal.
REQ-008 req_tag_i  input  4  caller tag, returned with the result.
REQ-009 alu_operand1_o / alu_operand2_o  output  32 each  to ALU operand ports.
REQ-010 alu_operator_o  output  2  to ALU operator port.
REQ-011 alu_result_i  input  32  ALU registered result, valid one cycle after operands are presented.
REQ-012 rsp_valid_o  output  1  response available.
REQ-013 rsp_ready_i  input  1  consumer takes response.
REQ-014 rsp_result_o  output  32  result at buffer head.
REQ-015 rsp_tag_o  output  4  tag at buffer head.
REQ-016 occupancy_o  output  $clog2(DEPTH)+1  buffered entries plus in-flight op.

Function
REQ-017 A request is accepted in any cycle where req_valid_i and req_ready_o are both 1.
REQ-018 alu_operand1_o, alu_operand2_o, alu_operator_o are combinational copies of req_op1_i, req_op2_i, req_operator_i in every cycle.
REQ-019 On acceptance in cycle N, the driver sets an in-flight flag and latches req_tag_i at the end of cycle N.
REQ-020 In cycle N+1 with in-flight set, alu_result_i and the latched tag are written to the buffer tail at the end of the cycle; in-flight clears unless a new request is accepted that same cycle.
REQ-021 Back-to-back acceptance each cycle is supported; throughput is one op per cycle when the buffer is not full.
REQ-022 req_ready_o = !rst and (buffered count + in-flight) < DEPTH.
REQ-023 rsp_valid_o = 1 when buffered count > 0; rsp_result_o/rsp_tag_o present the head entry and stay stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-024 Head pops at the end of a cycle with rsp_valid_o and rsp_ready_i both 1.
REQ-025 Minimum latency: accept in cycle N -> rsp_valid_o in cycle N+2 with the matching result.
REQ-026 Responses leave in acceptance order; no reordering.
REQ-027 Simultaneous write and pop in one cycle: count unchanged, both take effect; at full, a pop in the same cycle as the in-flight write is legal.
REQ-028 Buffer read/write pointers wrap modulo DEPTH.
REQ-029 Illegal operator 3 is forwarded unchanged; the resulting ALU value (0) is returned as a normal response.
REQ-030 occupancy_o = buffered count + in-flight flag, registered value.

Reset
REQ-031 While rst=1 at a rising edge: buffer count, pointers, in-flight flag cleared; latched tag set to 0.
REQ-032 During and after reset: rsp_valid_o=0, occupancy_o=0; req_ready_o=0 while rst=1, 1 in the first cycle after rst deasserts.
REQ-033 A request accepted in the cycle before reset asserts is discarded; its ALU result is never buffered.
REQ-034 Buffer data contents need not be reset.

Verification
REQ-035 Single op: accept op1=0xF0F0_F0F0, op2=0xFF00_FF00, XOR, tag 5 in cycle 0, rsp_ready_i=1 -> cycle 2 rsp_valid_o=1, result 0x0FF0_0FF0, tag 5.
REQ-036 Streaming: 8 back-to-back AND requests tags 0..7, rsp_ready_i=1 -> responses in cycles 2..9, tags in order, req_ready_o never drops.
REQ-037 Backpressure, DEPTH=4: rsp_ready_i=0, req_valid_i=1 continuously -> exactly 4 accepts, req_ready_o=0 from cycle 4, occupancy_o=4; raise rsp_ready_i -> all 4 drain in order, acceptance resumes.
REQ-038 Full with simultaneous pop: occupancy 4 with last op in flight, rsp_ready_i=1 that cycle -> no loss, count stays 4-element bounded, order preserved.
REQ-039 Illegal operator: operator 3, tag 9 -> response result 0x0000_0000, tag 9.
REQ-040 Reset mid-operation: 3 buffered + 1 in flight, assert rst one cycle -> next cycle rsp_valid_o=0, occupancy_o=0, req_ready_o=1; in-flight result never appears.
